// File: rtl/button_conditioner.sv
// Purpose: synchronise, debounce and edge-detect front-panel buttons; auto-repeat step pulses on selected channels.
// Latency: btn_raw edge to level/press/released between 2+(DEBOUNCE_MS-1)*TICK_DIV+1 and 2+DEBOUNCE_MS*TICK_DIV+1 cycles.
// Backpressure: none; pins are sampled every cycle and every output is a free-running registered pulse or level.
//
// The falling-edge pulse is named 'released' because 'release' is a reserved word in SystemVerilog.

module button_conditioner #(
  parameter int          N               = 7,
  parameter int          TICK_DIV        = 100000,
  parameter int          DEBOUNCE_MS     = 20,
  parameter int          REPEAT_DELAY_MS = 500,
  parameter int          REPEAT_MS       = 100,
  parameter logic [N-1:0] REPEAT_MASK    = 7'b0000011
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] btn_raw,
  output logic         tick_ms,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] released,
  output logic [N-1:0] step
);

  // Counter widths; a 1-bit floor keeps degenerate parameter values legal.
  localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W    = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam int REP_MAX = (REPEAT_DELAY_MS > REPEAT_MS) ? REPEAT_DELAY_MS : REPEAT_MS;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [REP_W-1:0] RD_LAST  = REP_W'(REPEAT_DELAY_MS - 1);
  localparam logic [REP_W-1:0] RM_LAST  = REP_W'(REPEAT_MS - 1);

  // Auto-repeat states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [PRE_W-1:0]         pre_cnt;
  logic [N-1:0]             meta;
  logic [N-1:0]             sync;
  logic [N-1:0][DB_W-1:0]   db_cnt;
  logic [N-1:0][REP_W-1:0]  rep_cnt;
  logic [N-1:0][1:0]        rep_state;
  logic [N-1:0]             disagree;
  logic [N-1:0]             flip;
  logic [N-1:0]             rise;
  logic [N-1:0]             fall;

  // Prescaler: free-running 0..TICK_DIV-1, tick_ms registered one cycle after the terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      tick_ms <= 1'b0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      tick_ms <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      tick_ms <= 1'b0;
    end
  end

  // Two-flop synchronizer; only sync is used past this point.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= btn_raw;
      sync <= meta;
    end
  end

  // Debounced edge detection: a level flips on the tick that completes DEBOUNCE_MS disagreeing ticks.
  always_comb begin
    disagree = '0;
    flip     = '0;
    rise     = '0;
    fall     = '0;
    for (int i = 0; i < N; i++) begin
      disagree[i] = sync[i] ^ level[i];
      flip[i]     = tick_ms & disagree[i] & (db_cnt[i] == DB_LAST);
      rise[i]     = flip[i] & sync[i];
      fall[i]     = flip[i] & ~sync[i];
    end
  end

  // Debounce counters, level and the press/released pulses that accompany a level change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt   <= '0;
      level    <= '0;
      press    <= '0;
      released <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        // Any agreeing cycle restarts the count; otherwise only ticks advance it.
        if (!disagree[i]) begin
          db_cnt[i] <= '0;
        end else if (tick_ms) begin
          if (db_cnt[i] == DB_LAST) begin
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end
      end
      level    <= level ^ flip;
      press    <= rise;
      released <= fall;
    end
  end

  // Auto-repeat FSM per channel; the press tick itself is not counted toward the first repeat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_state <= '0;
      rep_cnt   <= '0;
      step      <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        step[i] <= 1'b0;
        case (rep_state[i])
          ST_IDLE: begin
            if (rise[i]) begin
              step[i]      <= 1'b1;
              rep_cnt[i]   <= '0;
              rep_state[i] <= REPEAT_MASK[i] ? ST_DELAY : ST_IDLE;
            end
          end
          ST_DELAY: begin
            // Release wins over a coincident terminal tick so no step is emitted on release.
            if (fall[i]) begin
              rep_cnt[i]   <= '0;
              rep_state[i] <= ST_IDLE;
            end else if (tick_ms) begin
              if (rep_cnt[i] == RD_LAST) begin
                step[i]      <= 1'b1;
                rep_cnt[i]   <= '0;
                rep_state[i] <= ST_REPEAT;
              end else begin
                rep_cnt[i] <= rep_cnt[i] + 1'b1;
              end
            end
          end
          ST_REPEAT: begin
            if (fall[i]) begin
              rep_cnt[i]   <= '0;
              rep_state[i] <= ST_IDLE;
            end else if (tick_ms) begin
              if (rep_cnt[i] == RM_LAST) begin
                step[i]    <= 1'b1;
                rep_cnt[i] <= '0;
              end else begin
                rep_cnt[i] <= rep_cnt[i] + 1'b1;
              end
            end
          end
          default: begin
            rep_cnt[i]   <= '0;
            rep_state[i] <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with TICK_DIV=4, DEBOUNCE_MS=3, REPEAT_DELAY_MS=5, REPEAT_MS=2.
// Cycle c is the c-th rising edge after reset release; outputs are sampled on the following falling edge.
// Table rows check all outputs at a cycle and optionally drive new pin values; other cycles expect no pulses.

module tb_button_conditioner;

  logic       clk;
  logic       reset_n;
  logic [1:0] btn_raw;
  logic       tick_ms;
  logic [1:0] level;
  logic [1:0] press;
  logic [1:0] released;
  logic [1:0] step;

  int total;
  int bad;

  typedef struct {
    int         scn;
    int         cyc;
    bit         drv;
    logic [1:0] btn;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] stp;
  } vec_t;

  vec_t vecs[$];

  button_conditioner #(
    .N               (2),
    .TICK_DIV        (4),
    .DEBOUNCE_MS     (3),
    .REPEAT_DELAY_MS (5),
    .REPEAT_MS       (2),
    .REPEAT_MASK     (2'b01)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_raw  (btn_raw),
    .tick_ms  (tick_ms),
    .level    (level),
    .press    (press),
    .released (released),
    .step     (step)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void add(input int s, input int c, input bit d, input logic [1:0] b,
                              input logic [1:0] l, input logic [1:0] p,
                              input logic [1:0] r, input logic [1:0] st);
    vec_t v;
    v.scn = s; v.cyc = c; v.drv = d; v.btn = b;
    v.lvl = l; v.prs = p; v.rel = r; v.stp = st;
    vecs.push_back(v);
  endfunction

  // Assert reset asynchronously, check outputs clear before any edge, release on a falling edge.
  task automatic do_reset(input logic [1:0] b);
    reset_n = 1'b0;
    btn_raw = b;
    #1;
    total++;
    if ({tick_ms, level, press, released, step} !== 9'b0) begin
      bad++;
      $display("FAIL reset_clear got=%b want=000000000", {tick_ms, level, press, released, step});
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_scn(input int s);
    int   last;
    bit   hit;
    logic exp_tick;
    last = 0;
    foreach (vecs[k]) if (vecs[k].scn == s && vecs[k].cyc > last) last = vecs[k].cyc;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      @(negedge clk);
      hit = 1'b0;
      foreach (vecs[k]) begin
        if (vecs[k].scn == s && vecs[k].cyc == c) begin
          hit = 1'b1;
          total++;
          if ({level, press, released, step} !== {vecs[k].lvl, vecs[k].prs, vecs[k].rel, vecs[k].stp}) begin
            bad++;
            $display("FAIL vec scn=%0d cyc=%0d lvl/prs/rel/stp got=%b_%b_%b_%b want=%b_%b_%b_%b",
                     s, c, level, press, released, step,
                     vecs[k].lvl, vecs[k].prs, vecs[k].rel, vecs[k].stp);
          end
          if (vecs[k].drv) btn_raw = vecs[k].btn;
        end
      end
      if (!hit) begin
        total++;
        if ({press, released, step} !== 6'b0) begin
          bad++;
          $display("FAIL stray_pulse scn=%0d cyc=%0d prs/rel/stp got=%b_%b_%b want=00_00_00",
                   s, c, press, released, step);
        end
      end
      exp_tick = ((c % 4) == 0);
      total++;
      if (tick_ms !== exp_tick) begin
        bad++;
        $display("FAIL tick scn=%0d cyc=%0d got=%b want=%b", s, c, tick_ms, exp_tick);
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    btn_raw = 2'b00;

    //  scn cyc drv btn    lvl    prs    rel    stp
    // 0: idle after reset, ticks every 4 cycles starting at cycle 4
    add(0,  4, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(0, 40, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // 1: ch0 held; press at 13, repeats at 33, 41, 49
    add(1,  1, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 12, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 13, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01);
    add(1, 14, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, 33, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
    add(1, 41, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
    add(1, 49, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
    add(1, 50, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    // 2: 9-cycle glitch on ch0 spans only 2 ticks
    add(2,  1, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2, 10, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2, 30, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // 3: ch1 held 60 cycles, no auto-repeat, release 3 ticks after the pin drops
    add(3,  1, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    add(3, 13, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10);
    add(3, 61, 1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
    add(3, 72, 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
    add(3, 73, 0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
    add(3, 80, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // 4: one repeat, release lands on the would-be step cycle, re-press restarts the delay
    add(4,  1, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(4, 13, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01);
    add(4, 30, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(4, 33, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
    add(4, 41, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(4, 45, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(4, 57, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01);
    add(4, 76, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(4, 77, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
    add(4, 78, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    // 5: ch0 into REPEAT, then reset mid-repeat
    add(5,  1, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(5, 13, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01);
    add(5, 33, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
    add(5, 35, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    // 6: after reset with pin still high, fresh 3-tick debounce before press
    add(6, 12, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(6, 13, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01);
    add(6, 14, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);

    for (int s = 0; s <= 5; s++) begin
      do_reset(2'b00);
      run_scn(s);
    end

    // Channel 0 is in REPEAT here; reset is dropped between edges with the pin still high.
    #2;
    do_reset(2'b01);
    run_scn(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the raw front-panel pushbuttons and slide switches before they reach the clock/stopwatch core.
- Per channel, it provides:
  - a two-flop synchronizer
  - a tick-based debouncer
  - single-cycle press and release pulses
  - an optional auto-repeat "step" pulse, so that holding up or down slews hours or minutes at a controlled rate.
- It also exports the shared 1 ms tick it generates from clk.
- It sits between the board pins and the time-keeping block.

Parameters:
- N, 7, number of input channels.
- TICK_DIV, 100000, clk cycles per ms tick (100 MHz clk); must be ≥2.
- DEBOUNCE_MS, 20, consecutive ticks of disagreement required to flip a debounced level; must be ≥1.
- REPEAT_DELAY_MS, 500, ticks from press to first auto-repeat step; must be ≥1.
- REPEAT_MS, 100, ticks between subsequent auto-repeat steps; must be ≥1.
- REPEAT_MASK, 7'b0000011, bit i=1 enables auto-repeat on channel i (default: down and up).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- btn_raw  in  N  raw active-high pins, asynchronous to clk.
- tick_ms  out  1  one-cycle pulse every TICK_DIV cycles.
- level  out  N  debounced level.
- press  out  N  one-cycle pulse on debounced rising edge.
- release  out  N  one-cycle pulse on debounced falling edge.
- step  out  N  one-cycle pulse on press, plus auto-repeat pulses on enabled channels.

Behaviour:
- Reset:
  - Asserting reset_n low clears all state immediately (asynchronous), including mid-debounce and mid-repeat.
  - Reset values: every output 0; prescaler 0; sync flops 0; debounce and repeat counters 0; every channel IDLE.
  - Release of reset takes effect on the next clk edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 and then wraps to 0.
  - tick_ms is registered and is 1 exactly in the cycle after the count equals TICK_DIV-1.
  - The first tick_ms occurs TICK_DIV cycles after reset release.
- Synchronizer:
  - sync[i] = btn_raw[i] delayed through 2 flops.
  - Only sync is used downstream.
- Debounce, per channel, with registered db_cnt of width clog2(DEBOUNCE_MS):
  - Any cycle where sync == level: db_cnt <= 0.
  - Cycle with tick_ms=1 and sync != level:
    - If db_cnt == DEBOUNCE_MS-1: level <= sync and db_cnt <= 0.
    - Otherwise: db_cnt++.
  - A single agreeing cycle restarts the count.
  - Level therefore changes only on tick cycles, after DEBOUNCE_MS consecutive disagreeing ticks.
- press and release:
  - Registered at the same edge that flips level, so each is high in the first cycle level shows its new value.
  - At most one of the two fires per channel per cycle.
- Auto-repeat FSM, per channel, with states IDLE, DELAY, REPEAT and registered rep_cnt of width clog2(max(REPEAT_DELAY_MS, REPEAT_MS)):
  - IDLE: on press, step <= 1 and rep_cnt <= 0. Go to DELAY if REPEAT_MASK[i], otherwise stay IDLE.
  - DELAY, on a tick:
    - If rep_cnt == REPEAT_DELAY_MS-1: step <= 1, rep_cnt <= 0, go to REPEAT.
    - Otherwise: rep_cnt++.
  - REPEAT, on a tick:
    - If rep_cnt == REPEAT_MS-1: step <= 1, rep_cnt <= 0.
    - Otherwise: rep_cnt++.
  - DELAY or REPEAT on release: go to IDLE with rep_cnt <= 0. No step pulse is emitted in the release cycle.
  - The press cycle is itself a tick cycle and is not counted. The first repeat step therefore lands REPEAT_DELAY_MS ticks after press, and subsequent steps every REPEAT_MS ticks.
- Channel independence:
  - Channels are fully independent.
  - Simultaneous presses on several channels each produce their own pulses in the same cycle.
- Latency from btn_raw edge to level change:
  - Minimum: 2 + (DEBOUNCE_MS-1)·TICK_DIV + 1 cycles.
  - Maximum: 2 + DEBOUNCE_MS·TICK_DIV + 1 cycles.

Test Plan:
- All scenarios use TICK_DIV=4, DEBOUNCE_MS=3, REPEAT_DELAY_MS=5, REPEAT_MS=2, N=2, REPEAT_MASK=2'b01.
- Reset then idle for 40 cycles -> all outputs 0; tick_ms pulses every 4 cycles, the first one 4 cycles after reset release.
- btn_raw[0] held high -> level[0]=1, press[0]=1 and step[0]=1 together in one tick cycle (call it T0); step[0] pulses again at T0+20, T0+28, T0+36 cycles.
- btn_raw[0] high for 9 cycles (2 ticks) then low -> level, press and step stay 0 throughout.
- Channel 1 held for 60 cycles -> exactly one press[1]=1 and one step[1]=1 (no repeat); release[1] pulses 3 ticks after the pin drops.
- Channel 0 held until exactly one repeat step, then released -> release[0] fires with step[0]=0 in that cycle; no further steps; a re-press restarts the full 20-cycle delay before the first repeat.
- reset_n pulsed low while channel 0 is in REPEAT -> outputs go to 0 immediately, without waiting for a clk edge; after release of reset with the pin still high, a fresh debounce of 3 ticks precedes press[0].
